mem_arbiter: RTL

Request-level arbiter and scheduler in front of the byte-serial memory engine. It accepts word/half/byte requests from three requesters: instruction fetch (IFU), load port of the LSB, and store port of the LSB. It grants the engine to one requester at a time under store > load > fetch priority, with a fetch anti-starvation counter and IO back-pressure gating. It routes the engine's completion and read data back to the granted requester, and handles `roll_back` squashes.

---
 rtl/mem_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Request arbiter in front of the byte-serial memory engine: store > load > fetch,
// with fetch anti-starvation, IO back-pressure gating and roll_back squash handling.
`timescale 1ns/1ps
module mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 8,
   parameter logic [5:0]  OP_LW        = 6'd3
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        roll_back,
   input  logic        io_buffer_full,
   input  logic        ifu_req,
   input  logic [31:0] ifu_addr,
   output logic        ifu_done,
   output logic [31:0] ifu_data,
   input  logic        ld_req,
   input  logic [31:0] ld_addr,
   input  logic [5:0]  ld_op,
   output logic        ld_done,
   output logic [31:0] ld_data,
   input  logic        st_req,
   input  logic [31:0] st_addr,
   input  logic [5:0]  st_op,
   input  logic [31:0] st_data,
   output logic        st_done,
   output logic        eng_start,
   output logic [31:0] eng_addr,
   output logic [5:0]  eng_op,
   output logic        eng_we,
   output logic [31:0] eng_wdata,
   output logic        eng_abort,
   input  logic        eng_done,
   input  logic [31:0] eng_rdata,
   output logic [1:0]  grant_id,
   output logic        arb_idle
);
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   localparam logic [1:0] GID_NONE = 2'd0;
   localparam logic [1:0] GID_IFU  = 2'd1;
   localparam logic [1:0] GID_LD   = 2'd2;
   localparam logic [1:0] GID_ST   = 2'd3;
   localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   state_t        state_q, state_d;
   logic [1:0]    grant_id_q, grant_id_d;
   logic [CW-1:0] starve_cnt_q, starve_cnt_d;
   logic          eng_start_q, eng_start_d;
   logic          eng_abort_q, eng_abort_d;
   logic          eng_we_q, eng_we_d;
   logic [31:0]   eng_addr_q, eng_addr_d;
   logic [31:0]   eng_wdata_q, eng_wdata_d;
   logic [5:0]    eng_op_q, eng_op_d;
   logic          ifu_done_q, ifu_done_d;
   logic          ld_done_q, ld_done_d;
   logic          st_done_q, st_done_d;
   logic [31:0]   ifu_data_q, ifu_data_d;
   logic [31:0]   ld_data_q, ld_data_d;
   logic          arb_idle_q, arb_idle_d;
   logic          st_ok, ld_ok;
   logic [1:0]    pick;

   // Winner of this cycle's arbitration; IO-space accesses wait while the IO buffer is full.
   always_comb begin
      st_ok = st_req && !(io_buffer_full && (st_addr[17:16] == 2'b11));
      ld_ok = ld_req && !(io_buffer_full && (ld_addr[17:16] == 2'b11));
      pick  = GID_NONE;
      if ((starve_cnt_q == LIMIT) && ifu_req) pick = GID_IFU;
      else if (st_ok)                         pick = GID_ST;
      else if (ld_ok)                         pick = GID_LD;
      else if (ifu_req)                       pick = GID_IFU;
      if ((state_q != IDLE) || roll_back) pick = GID_NONE;
   end

   always_comb begin
      state_d     = state_q;
      grant_id_d  = grant_id_q;
      eng_addr_d  = eng_addr_q;
      eng_op_d    = eng_op_q;
      eng_we_d    = eng_we_q;
      eng_wdata_d = eng_wdata_q;
      ifu_data_d  = ifu_data_q;
      ld_data_d   = ld_data_q;
      eng_start_d = 1'b0;
      eng_abort_d = 1'b0;
      ifu_done_d  = 1'b0;
      ld_done_d   = 1'b0;
      st_done_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pick != GID_NONE) begin
               state_d     = BUSY;
               grant_id_d  = pick;
               eng_start_d = 1'b1;
               unique case (pick)
                  GID_ST: begin
                     eng_addr_d  = st_addr;
                     eng_op_d    = st_op;
                     eng_we_d    = 1'b1;
                     eng_wdata_d = st_data;
                  end
                  GID_LD: begin
                     eng_addr_d  = ld_addr;
                     eng_op_d    = ld_op;
                     eng_we_d    = 1'b0;
                     eng_wdata_d = 32'd0;
                  end
                  default: begin
                     eng_addr_d  = ifu_addr;
                     eng_op_d    = OP_LW;
                     eng_we_d    = 1'b0;
                     eng_wdata_d = 32'd0;
                  end
               endcase
            end
         end
         BUSY: begin
            // A committed store cannot be squashed; reads are abandoned and any completion dropped.
            if (roll_back && (grant_id_q != GID_ST)) begin
               eng_abort_d = 1'b1;
               state_d     = IDLE;
               grant_id_d  = GID_NONE;
            end else if (eng_done) begin
               state_d = RESP;
               unique case (grant_id_q)
                  GID_IFU: begin ifu_data_d = eng_rdata; ifu_done_d = 1'b1; end
                  GID_LD:  begin ld_data_d  = eng_rdata; ld_done_d  = 1'b1; end
                  default: st_done_d = 1'b1;
               endcase
            end
         end
         RESP: begin
            state_d    = IDLE;
            grant_id_d = GID_NONE;
         end
         default: state_d = IDLE;
      endcase
      arb_idle_d = (state_d == IDLE);

      if (roll_back || !ifu_req || (pick == GID_IFU)) starve_cnt_d = '0;
      else if (((pick == GID_ST) || (pick == GID_LD)) && (starve_cnt_q != LIMIT))
         starve_cnt_d = starve_cnt_q + CW'(1);
      else starve_cnt_d = starve_cnt_q;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q      <= IDLE;
         grant_id_q   <= GID_NONE;
         starve_cnt_q <= '0;
         eng_start_q  <= 1'b0;
         eng_abort_q  <= 1'b0;
         eng_we_q     <= 1'b0;
         eng_addr_q   <= 32'd0;
         eng_op_q     <= 6'd0;
         eng_wdata_q  <= 32'd0;
         ifu_done_q   <= 1'b0;
         ld_done_q    <= 1'b0;
         st_done_q    <= 1'b0;
         ifu_data_q   <= 32'd0;
         ld_data_q    <= 32'd0;
         arb_idle_q   <= 1'b1;
      end else if (rdy_in) begin
         state_q      <= state_d;
         grant_id_q   <= grant_id_d;
         starve_cnt_q <= starve_cnt_d;
         eng_start_q  <= eng_start_d;
         eng_abort_q  <= eng_abort_d;
         eng_we_q     <= eng_we_d;
         eng_addr_q   <= eng_addr_d;
         eng_op_q     <= eng_op_d;
         eng_wdata_q  <= eng_wdata_d;
         ifu_done_q   <= ifu_done_d;
         ld_done_q    <= ld_done_d;
         st_done_q    <= st_done_d;
         ifu_data_q   <= ifu_data_d;
         ld_data_q    <= ld_data_d;
         arb_idle_q   <= arb_idle_d;
      end
   end

   // A squash arriving during the response cycle suppresses a read's done pulse.
   assign ifu_done  = ifu_done_q & ~(roll_back & rdy_in);
   assign ld_done   = ld_done_q & ~(roll_back & rdy_in);
   assign st_done   = st_done_q;
   assign ifu_data  = ifu_data_q;
   assign ld_data   = ld_data_q;
   assign eng_start = eng_start_q;
   assign eng_abort = eng_abort_q;
   assign eng_addr  = eng_addr_q;
   assign eng_op    = eng_op_q;
   assign eng_we    = eng_we_q;
   assign eng_wdata = eng_wdata_q;
   assign grant_id  = grant_id_q;
   assign arb_idle  = arb_idle_q;
endmodule
